call_return_stack: RTL

//  Hardware LIFO of return addresses for the RAT CPU. Complements the program counter:
//  - CALL pushes PC_COUNT+1; RET pops the top entry.
//  - RET_ADDR feeds the PC DIN mux.
//  - Sits beside the PC and is driven by the control unit's PUSH/POP strobes.
//  - Reports depth, full/empty and sticky overflow/underflow errors.

---
 rtl/call_return_stack.sv | 95 +++++++++
 1 files changed

// File: rtl/call_return_stack.sv
// call_return_stack: LIFO of return addresses for the RAT CPU.
// CALL pushes PC_COUNT+1, RET pops the top. RET_ADDR, EMPTY and FULL are
// derived combinationally from the registered count and storage.
// OVF and UNF are sticky error flags that CLR_ERR clears.
module call_return_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] PC_COUNT,
  input  logic             PUSH,
  input  logic             POP,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] RET_ADDR,
  output logic [CW-1:0]    CNT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF,
  output logic             UNF
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_ovf, r_unf;

  logic             w_empty, w_full;
  logic [WIDTH-1:0] w_push_val;
  logic [AW-1:0]    w_top_idx, w_wr_idx;
  logic             w_wr_en, w_inc, w_dec, w_ovf_set, w_unf_set;

  assign w_empty    = (r_cnt == '0);
  assign w_full     = (r_cnt == CW'(DEPTH));
  // The sum wraps naturally at WIDTH bits, so 0x3FF+1 stores 0x000.
  assign w_push_val = PC_COUNT + 1'b1;
  assign w_top_idx  = AW'(r_cnt - 1'b1);

  // Decode the strobes into one action per edge. PUSH+POP on a non-empty
  // stack overwrites the top in place; on an empty stack it acts as a push.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = AW'(r_cnt);
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    if (PUSH && POP) begin
      w_wr_en = 1'b1;
      if (w_empty) begin
        w_inc = 1'b1;
      end else begin
        w_wr_idx = w_top_idx;
      end
    end else if (PUSH) begin
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_wr_en = 1'b1;
        w_inc   = 1'b1;
      end
    end else if (POP) begin
      if (w_empty) w_unf_set = 1'b1;
      else         w_dec     = 1'b1;
    end
  end

  // Storage write; contents are not reset since nothing is visible while empty.
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_push_val;
  end

  // Count and sticky flags; a new error event wins over CLR_ERR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_inc)      r_cnt <= r_cnt + 1'b1;
      else if (w_dec) r_cnt <= r_cnt - 1'b1;
      r_ovf <= w_ovf_set | (r_ovf & ~CLR_ERR);
      r_unf <= w_unf_set | (r_unf & ~CLR_ERR);
    end
  end

  assign RET_ADDR = w_empty ? '0 : r_mem[w_top_idx];
  assign CNT      = r_cnt;
  assign EMPTY    = w_empty;
  assign FULL     = w_full;
  assign OVF      = r_ovf;
  assign UNF      = r_unf;

endmodule
